// File: rtl/hc_stream_xor_if.sv
// hc_stream_xor_if: keystream and data-stream signals of the HC stream XOR block.
//   ks_next/ks_word/ks_valid       request/valid link to the cipher core
//   din/din_valid/din_ready        input data stream
//   dout/dout_valid/dout_ready     output data stream
// Modport master is the XOR block; modport slave is the core plus data endpoints.
interface hc_stream_xor_if;
   logic        ks_next;
   logic [31:0] ks_word;
   logic        ks_valid;
   logic [31:0] din;
   logic        din_valid;
   logic        din_ready;
   logic [31:0] dout;
   logic        dout_valid;
   logic        dout_ready;

   modport master (
      output ks_next,
      input  ks_word,
      input  ks_valid,
      input  din,
      input  din_valid,
      output din_ready,
      output dout,
      output dout_valid,
      input  dout_ready
   );

   modport slave (
      input  ks_next,
      output ks_word,
      output ks_valid,
      output din,
      output din_valid,
      input  din_ready,
      input  dout,
      input  dout_valid,
      output dout_ready
   );
endinterface

// File: rtl/hc_stream_xor.sv
// hc_stream_xor: keystream consumer for the HC stream cipher datapath.
// Fetches 32-bit keystream words from the cipher core (one request outstanding at a time),
// prefetches them into a KS_DEPTH-word FIFO and XORs them one-for-one with the data stream.
// Encryption and decryption are the same operation.
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   enable     allows keystream requests (data path unaffected)
//   flush      one-cycle pulse: drop buffered/in-flight keystream, clear status
//   bus        keystream link and data streams (hc_stream_xor_if.master)
//   words_out  count of completed dout handshakes (wraps)
//   ks_error   sticky: ks_valid arrived with no request outstanding
module hc_stream_xor #(
   parameter int unsigned KS_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   flush,
   hc_stream_xor_if.master        bus,
   output logic [31:0]            words_out,
   output logic                   ks_error
);

   localparam int unsigned PtrW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] DepthCnt = CntW'(KS_DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

   state_e          state_q, state_d;
   logic            ks_next_q, ks_next_d;
   logic            ks_error_q, ks_error_d;
   logic [31:0]     mem_q [KS_DEPTH];
   logic [31:0]     mem_d [KS_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [31:0]     dout_q, dout_d;
   logic            dout_valid_q, dout_valid_d;
   logic [31:0]     words_q, words_d;

   logic            din_ready;
   logic            din_hs;
   logic            dout_hs;
   logic            ks_push;

   // Fetch FSM: next state and registered request pulse.
   always_comb begin
      state_d    = state_q;
      ks_next_d  = 1'b0;
      ks_error_d = ks_error_q;
      case (state_q)
         StIdle: begin
            if (bus.ks_valid) begin
               ks_error_d = 1'b1;
            end
            if (enable && (count_q < DepthCnt)) begin
               state_d   = StWait;
               ks_next_d = 1'b1;
            end
         end
         StWait: begin
            if (bus.ks_valid) begin
               state_d = StIdle;
            end
         end
         StDiscard: begin
            if (bus.ks_valid) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // A word still owed by the core must be swallowed when it finally arrives.
      if (flush) begin
         ks_next_d  = 1'b0;
         ks_error_d = 1'b0;
         state_d    = ((state_q != StIdle) && !bus.ks_valid) ? StDiscard : StIdle;
      end
   end

   // Keystream FIFO and output register.
   always_comb begin
      din_ready = (count_q != '0) & (~dout_valid_q | bus.dout_ready) & ~flush;
      din_hs    = bus.din_valid & din_ready;
      dout_hs   = dout_valid_q & bus.dout_ready;
      ks_push   = (state_q == StWait) & bus.ks_valid & ~flush;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (ks_push) begin
         mem_d[wr_ptr_q] = bus.ks_word;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (din_hs) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({ks_push, din_hs})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      words_d      = words_q;
      if (dout_hs) begin
         words_d = words_q + 32'd1;
      end
      if (din_hs) begin
         dout_d       = bus.din ^ mem_q[rd_ptr_q];
         dout_valid_d = 1'b1;
      end else if (dout_hs) begin
         dout_valid_d = 1'b0;
      end

      if (flush) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         dout_valid_d = 1'b0;
         words_d      = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         ks_next_q    <= 1'b0;
         ks_error_q   <= 1'b0;
         mem_q        <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         words_q      <= '0;
      end else begin
         state_q      <= state_d;
         ks_next_q    <= ks_next_d;
         ks_error_q   <= ks_error_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         words_q      <= words_d;
      end
   end

   assign bus.ks_next    = ks_next_q;
   assign bus.din_ready  = din_ready;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign words_out      = words_q;
   assign ks_error       = ks_error_q;

endmodule

// File: tb/tb_hc_stream_xor.sv
// tb_hc_stream_xor: directed sequence with random data and keystream, checked against a
// queue-based reference: every keystream word the core delivers and that was not cancelled by
// flush/reset is used exactly once, in order, and dout = din ^ that word.
module tb_hc_stream_xor;
   localparam int unsigned Depth = 4;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        flush;
   logic [31:0] words_out;
   logic        ks_error;

   hc_stream_xor_if bus ();

   hc_stream_xor #(.KS_DEPTH(Depth)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .flush     (flush),
      .bus       (bus),
      .words_out (words_out),
      .ks_error  (ks_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_vec = 0;
   int          n_err = 0;
   // Core model state (written only by core_model).
   logic [31:0] kept[$];
   int          flush_mark;
   bit          busy;
   int          inject_done;
   // Core knobs (written only by the main sequence).
   bit          fixed_en = 1'b1;
   logic [31:0] fixed_word = 32'hA5A5A5A5;
   int          lat_min = 3;
   int          lat_max = 3;
   int          inject_req = 0;
   // Reference state.
   logic [31:0] exp_q[$];
   int          rd_idx = 0;
   logic [31:0] words_exp = '0;
   int          nxt_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Cipher core: answers each ks_next after a random latency; remembers which words the
   // block should keep (a flush between request and delivery cancels the word).
   initial begin : core_model
      int          cnt;
      bit          drop;
      logic [31:0] w;
      cnt = 0;
      drop = 1'b0;
      w = '0;
      busy = 1'b0;
      flush_mark = 0;
      inject_done = 0;
      bus.ks_valid = 1'b0;
      bus.ks_word = '0;
      forever begin
         @(negedge clk);
         bus.ks_valid = 1'b0;
         if (!reset_n) begin
            busy = 1'b0;
            flush_mark = int'(kept.size());
         end else begin
            if (flush) flush_mark = int'(kept.size());
            if (busy) begin
               if (flush) drop = 1'b1;
               cnt--;
               if (cnt == 0) begin
                  bus.ks_valid = 1'b1;
                  bus.ks_word = w;
                  busy = 1'b0;
                  if (!drop) kept.push_back(w);
               end
            end else if (inject_done != inject_req) begin
               bus.ks_valid = 1'b1;
               bus.ks_word = $urandom();
               inject_done++;
            end
            if (bus.ks_next) begin
               busy = 1'b1;
               cnt = int'($urandom_range(lat_max, lat_min));
               drop = flush;
               w = fixed_en ? fixed_word : $urandom();
            end
         end
      end
   end

   // Per-cycle reference check, sampled mid-cycle.
   task automatic eval_cycle();
      if (rd_idx < flush_mark) rd_idx = flush_mark;
      check("words_out", words_out, words_exp);
      check("dout_valid", 32'(bus.dout_valid), 32'(exp_q.size() != 0));
      if (bus.ks_next) nxt_cnt++;
      if (flush) begin
         exp_q.delete();
         words_exp = '0;
      end else begin
         if (bus.dout_valid && bus.dout_ready) begin
            if (exp_q.size() != 0) check("dout_data", bus.dout, exp_q.pop_front());
            words_exp = words_exp + 32'd1;
         end
         if (bus.din_valid && bus.din_ready) begin
            check("ks_avail", 32'(rd_idx < int'(kept.size())), 32'd1);
            if (rd_idx < int'(kept.size())) begin
               exp_q.push_back(bus.din ^ kept[rd_idx]);
               rd_idx++;
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
      eval_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ks_next"}, 32'(bus.ks_next), 32'd0);
      check({tag, "_din_ready"}, 32'(bus.din_ready), 32'd0);
      check({tag, "_dout"}, bus.dout, 32'd0);
      check({tag, "_dout_valid"}, 32'(bus.dout_valid), 32'd0);
      check({tag, "_words_out"}, words_out, 32'd0);
      check({tag, "_ks_error"}, 32'(ks_error), 32'd0);
   endtask

   initial begin : main
      logic [31:0] d;
      int          model_cnt;
      int          nacc;
      reset_n = 1'b1;
      enable = 1'b0;
      flush = 1'b0;
      bus.din = '0;
      bus.din_valid = 1'b0;
      bus.dout_ready = 1'b0;
      #1 reset_n = 1'b0;
      #1 check_reset_outputs("rst0");
      repeat (3) @(posedge clk);
      #1;

      // Release with enable high: first request in the next cycle.
      enable = 1'b1;
      reset_n = 1'b1;
      step();
      check("first_req", 32'(bus.ks_next), 32'd1);

      // Basic XOR with a fixed keystream word.
      for (int i = 0; i < 40 && !bus.din_ready; i++) step();
      check("basic_ready", 32'(bus.din_ready), 32'd1);
      bus.dout_ready = 1'b1;
      bus.din = 32'h12345678;
      bus.din_valid = 1'b1;
      step();
      bus.din_valid = 1'b0;
      check("basic_valid", 32'(bus.dout_valid), 32'd1);
      check("basic_dout", bus.dout, 32'h12345678 ^ 32'hA5A5A5A5);
      step();
      check("basic_words", words_out, 32'd1);
      fixed_en = 1'b0;
      lat_min = 1;
      lat_max = 3;

      // Prefetch: fill, flush, refill counts exactly Depth requests.
      repeat (30) step();
      flush = 1'b1;
      #1 check("flush_din_ready", 32'(bus.din_ready), 32'd0);
      step();
      flush = 1'b0;
      nxt_cnt = 0;
      repeat (40) step();
      check("prefetch_cnt", 32'(nxt_cnt), 32'(Depth));
      bus.din = $urandom();
      bus.din_valid = 1'b1;
      step();
      bus.din_valid = 1'b0;
      nxt_cnt = 0;
      repeat (20) step();
      check("refill_cnt", 32'(nxt_cnt), 32'd1);

      // Backpressure: one word held in dout, no further accepts.
      bus.dout_ready = 1'b0;
      bus.din_valid = 1'b1;
      bus.din = $urandom();
      step();
      for (int i = 0; i < 9; i++) begin
         check("bp_valid", 32'(bus.dout_valid), 32'd1);
         check("bp_hold", bus.dout, (exp_q.size() != 0) ? exp_q[0] : 32'hxxxxxxxx);
         check("bp_din_ready", 32'(bus.din_ready), 32'd0);
         bus.din = $urandom();
         step();
      end
      bus.dout_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.din = $urandom();
         step();
      end
      bus.din_valid = 1'b0;
      repeat (3) step();

      // Flush while a request is outstanding: the DEADBEEF word is dropped.
      enable = 1'b0;
      for (int i = 0; i < 10 && busy; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      fixed_en = 1'b1;
      fixed_word = 32'hDEADBEEF;
      lat_min = 4;
      lat_max = 4;
      enable = 1'b1;
      for (int i = 0; i < 10 && !bus.ks_next; i++) step();
      check("mid_req", 32'(bus.ks_next), 32'd1);
      step();
      fixed_en = 1'b0;
      lat_min = 1;
      lat_max = 3;
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_no_req", 32'(bus.ks_next), 32'd0);
      check("flush_words", words_out, 32'd0);
      for (int i = 0; i < 40 && !bus.din_ready; i++) step();
      check("flush_ready", 32'(bus.din_ready), 32'd1);
      d = $urandom();
      bus.din = d;
      bus.din_valid = 1'b1;
      step();
      bus.din_valid = 1'b0;
      check("flush_drop", 32'(bus.dout == (d ^ 32'hDEADBEEF)), 32'd0);
      repeat (2) step();

      // Unsolicited ks_valid while idle.
      repeat (30) step();
      enable = 1'b0;
      for (int i = 0; i < 10 && busy; i++) step();
      step();
      check("err_pre", 32'(ks_error), 32'd0);
      if (rd_idx < flush_mark) rd_idx = flush_mark;
      model_cnt = int'(kept.size()) - rd_idx;
      inject_req++;
      step();
      step();
      check("err_set", 32'(ks_error), 32'd1);
      bus.din_valid = 1'b1;
      nacc = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.din_ready) nacc++;
         bus.din = $urandom();
         step();
      end
      bus.din_valid = 1'b0;
      check("err_fifo_cnt", 32'(nacc), 32'(model_cnt));
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("err_clear", 32'(ks_error), 32'd0);

      // Reset mid-stream with a word held in dout.
      enable = 1'b1;
      for (int i = 0; i < 40 && !bus.din_ready; i++) step();
      bus.dout_ready = 1'b0;
      bus.din = $urandom();
      bus.din_valid = 1'b1;
      step();
      bus.din_valid = 1'b0;
      check("rst_pre_valid", 32'(bus.dout_valid), 32'd1);
      reset_n = 1'b0;
      exp_q.delete();
      words_exp = '0;
      #1 check_reset_outputs("rst1");
      repeat (2) step();
      reset_n = 1'b1;
      step();
      check("rst_first_req", 32'(bus.ks_next), 32'd1);
      bus.dout_ready = 1'b1;
      repeat (5) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
